// File: rtl/cu_alu_pipe_if.sv
// EX-slot control bus between the ID stage and cu_alu_pipe.
// master drives the issue side, slave returns the registered EX controls.
interface cu_alu_pipe_if #(
   parameter int STEPW = 2
);
   logic             in_valid;
   logic [3:0]       op_code;
   logic [1:0]       ra;
   logic             int_req;
   logic             stall;
   logic             flush;
   logic             ex_valid;
   logic [3:0]       ALU_CONTROL;
   logic             SE2;
   logic [1:0]       SE3;
   logic             int_busy;
   logic [STEPW-1:0] int_step;
   logic             illegal;

   modport master (
      output in_valid, op_code, ra, int_req, stall, flush,
      input  ex_valid, ALU_CONTROL, SE2, SE3, int_busy, int_step,
             illegal
   );

   modport slave (
      input  in_valid, op_code, ra, int_req, stall, flush,
      output ex_valid, ALU_CONTROL, SE2, SE3, int_busy, int_step,
             illegal
   );
endinterface

// File: rtl/cu_alu_pipe.sv
// Registered ALU control decoder with an EX slot, stall/flush and a
// multi-cycle interrupt-entry sequencer issuing SP-pass slots.
module cu_alu_pipe #(
   parameter int INT_CYCLES = 2,
   parameter int STEPW      = 2
) (
   input logic          clk,
   input logic          rst_n,
   cu_alu_pipe_if.slave bus
);
   typedef enum logic [1:0] {
      S_IDLE,
      S_INT,
      S_DRAIN
   } state_t;

   localparam logic [STEPW-1:0] LAST = STEPW'(INT_CYCLES - 1);

   state_t           r_state, w_nstate;
   logic             r_valid, w_nvalid;
   logic [3:0]       r_ctl, w_nctl;
   logic             r_se2, w_nse2;
   logic [1:0]       r_se3, w_nse3;
   logic [STEPW-1:0] r_step, w_nstep;
   logic             r_ill, w_nill;

   logic [3:0] w_ctl;
   logic       w_se2;
   logic [1:0] w_se3;
   logic       w_ill;
   logic [3:0] w_op;
   logic [1:0] w_ra;

   assign w_op = bus.op_code;
   assign w_ra = bus.ra;

   always_comb begin
      w_ctl = 4'h0;
      w_se2 = 1'b0;
      w_se3 = 2'b00;
      w_ill = 1'b0;
      unique case (1'b1)
         w_op == 4'h1: w_se3 = 2'b10;
         w_op inside {[4'h2:4'h5]}: w_ctl = w_op;
         w_op == 4'h6: w_ctl = 4'h6 + {2'b00, w_ra};
         w_op == 4'h7: begin
            w_se2 = 1'b1;
            unique case (w_ra)
               2'b00: w_se3 = 2'b01;
               2'b01: w_ctl = 4'h2;
               2'b10: w_se3 = 2'b10;
               default: ;
            endcase
         end
         w_op == 4'h8: w_ctl = 4'hA + {2'b00, w_ra};
         w_op == 4'hA: begin
            w_ctl = 4'h3;
            w_se2 = 1'b1;
         end
         w_op == 4'hB: begin
            w_se2 = 1'b1;
            unique case (w_ra)
               2'b01: w_se3 = 2'b01;
               2'b10,
               2'b11: w_ctl = 4'h2;
               default: ;
            endcase
         end
         w_op inside {[4'hC:4'hE]}: w_se3 = 2'b01;
         w_op == 4'hF: w_ill = 1'b1;
         default: ;
      endcase
   end

   // DRAIN hands back to ID in the same edge it leaves, so the held
   // instruction lands in EX as soon as int_busy drops.
   always_comb begin
      w_nstate = r_state;
      w_nvalid = r_valid;
      w_nctl   = r_ctl;
      w_nse2   = r_se2;
      w_nse3   = r_se3;
      w_nstep  = r_step;
      w_nill   = r_ill;
      if (!bus.stall) begin
         unique case (r_state)
            S_IDLE: begin
               if (bus.flush) begin
                  w_nvalid = 1'b0;
                  w_nctl   = 4'h0;
                  w_nse2   = 1'b0;
                  w_nse3   = 2'b00;
                  w_nill   = 1'b0;
               end else if (bus.int_req) begin
                  w_nstate = S_INT;
                  w_nvalid = 1'b1;
                  w_nctl   = 4'h0;
                  w_nse2   = 1'b0;
                  w_nse3   = 2'b01;
                  w_nill   = 1'b0;
                  w_nstep  = '0;
               end else begin
                  w_nvalid = bus.in_valid;
                  w_nctl   = bus.in_valid ? w_ctl : 4'h0;
                  w_nse2   = bus.in_valid & w_se2;
                  w_nse3   = bus.in_valid ? w_se3 : 2'b00;
                  w_nill   = bus.in_valid & w_ill;
               end
            end
            S_INT: begin
               if (r_step == LAST) begin
                  w_nstate = S_DRAIN;
                  w_nvalid = 1'b0;
                  w_nse3   = 2'b00;
                  w_nstep  = '0;
               end else begin
                  w_nvalid = 1'b1;
                  w_nse3   = 2'b01;
                  w_nstep  = r_step + STEPW'(1);
               end
               w_nctl = 4'h0;
               w_nse2 = 1'b0;
               w_nill = 1'b0;
            end
            S_DRAIN: begin
               w_nstate = S_IDLE;
               w_nvalid = bus.in_valid;
               w_nctl   = bus.in_valid ? w_ctl : 4'h0;
               w_nse2   = bus.in_valid & w_se2;
               w_nse3   = bus.in_valid ? w_se3 : 2'b00;
               w_nill   = bus.in_valid & w_ill;
               w_nstep  = '0;
            end
            default: w_nstate = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_valid <= 1'b0;
         r_ctl   <= 4'h0;
         r_se2   <= 1'b0;
         r_se3   <= 2'b00;
         r_step  <= '0;
         r_ill   <= 1'b0;
      end else begin
         r_state <= w_nstate;
         r_valid <= w_nvalid;
         r_ctl   <= w_nctl;
         r_se2   <= w_nse2;
         r_se3   <= w_nse3;
         r_step  <= w_nstep;
         r_ill   <= w_nill;
      end
   end

   assign bus.ex_valid    = r_valid;
   assign bus.ALU_CONTROL = r_ctl;
   assign bus.SE2         = r_se2;
   assign bus.SE3         = r_se3;
   assign bus.int_busy    = (r_state != S_IDLE);
   assign bus.int_step    = r_step;
   assign bus.illegal     = r_ill;
endmodule

// File: doc/cu_alu_pipe.md
Name: cu_alu_pipe

Overview:
Registered, interrupt-sequencing successor of the combinational ALU control decoder. It decodes op_code/ra into ALU_CONTROL, SE2 and SE3, and registers them into the EX-stage slot with stall and flush support. The single-cycle "registered interrupt flag" override is replaced by a parametrised multi-cycle interrupt-entry FSM. It sits between the ID/EX pipeline register and the ALU/operand muxes.

Parameters:
INT_CYCLES, 2, number of SP-pass slots issued per interrupt entry (legal 1..4)
STEPW, 2, width of int_step (must satisfy 2^STEPW >= INT_CYCLES)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  ID stage presents a valid instruction
op_code  in  4  instruction opcode
ra  in  2  ra field / sub-opcode
int_req  in  1  interrupt request, level, sampled on clk
stall  in  1  hold the EX slot and FSM
flush  in  1  squash the instruction entering EX
ex_valid  out  1  EX slot holds a live op
ALU_CONTROL  out  4  registered ALU operation
SE2  out  1  registered: 1 -> constant 1, 0 -> R[rb]
SE3  out  2  registered: 0 -> ALU_res, 1 -> R[ra]/SP/IMM, 2 -> R[rb]
int_busy  out  1  FSM in interrupt entry; ID must hold its instruction
int_step  out  STEPW  index of the current interrupt slot
illegal  out  1  registered: EX op was opcode 4'b1111

Behaviour:
- Reset (rst_n=0, async): ex_valid=0, ALU_CONTROL=0, SE2=0, SE3=0, int_busy=0, int_step=0, illegal=0, FSM=IDLE. Release takes effect on the next clk edge.
- Decode (combinational, then registered; latency 1 clk). Default is ctl=0000, SE2=0, SE3=00.
  - 0001 MOV: SE3=10.
  - 0010/0011/0100/0101: ctl = op_code (ADD/SUB/AND/OR).
  - 0110, ctl by ra: 00->0110 RLC, 01->0111 RRC, 10->1000 SETC, 11->1001 CLRC.
  - 0111, SE2=1 for all ra: ra=00 PUSH: SE3=01; ra=01 POP: ctl=0010, SE3=00; ra=10 OUT: SE3=10; ra=11: ctl=0000, SE3=00.
  - 1000, ctl by ra: 00->1010 NOT, 01->1011 NEG, 10->1100 INC, 11->1101 DEC.
  - 1010 LOOP: ctl=0011, SE2=1.
  - 1011, SE2=1 for all ra: ra=01 CALL: SE3=01; ra=10/11 RET/RTI: ctl=0010, SE3=00; ra=00: ctl=0000, SE3=00.
  - 1100/1101/1110: SE3=01.
  - 1111: all defaults, illegal=1.
  - All other opcodes: defaults.
- FSM states:
  - IDLE: normal issue.
  - INT: issue interrupt slots.
  - DRAIN: one bubble cycle, then return to IDLE.
- Per-clock priority: rst_n > stall > INT/DRAIN sequencing > flush > int_req > normal load.
- stall=1: every output register and the FSM hold. int_req is not sampled.
- IDLE, flush=1: load a bubble (ex_valid=0, decode defaults, illegal=0).
- IDLE, int_req=1 (and flush=0): go to INT with int_step=0. The load that cycle is slot 0: ex_valid=1, ctl=0000, SE2=0, SE3=01. int_busy=1 from this edge. The in-flight ID instruction is not loaded; ID holds it.
- IDLE, otherwise: load the decode; ex_valid=in_valid. When in_valid=0, load defaults.
- INT: each unstalled clk increments int_step and loads another SP-pass slot. After INT_CYCLES slots total, go to DRAIN.
  - int_busy=1 in INT and DRAIN.
  - flush and int_req are ignored in INT and DRAIN.
  - Interrupt slots are never squashed.
- DRAIN: load a bubble, int_step=0, then go to IDLE. int_busy falls on that edge. int_req still high in the IDLE cycle that follows starts a new entry (level-sensitive; the source must clear it).
- Interrupt entry occupies INT_CYCLES+1 clocks plus any stall cycles.
- Reset mid-sequence: immediate IDLE. No slot is replayed.

Test Plan:
- Reset, then in_valid=1, op=0010 -> next edge ex_valid=1, ALU_CONTROL=0010, SE2=0, SE3=00. Assert rst_n=0 mid-cycle -> all outputs 0 immediately.
- Sweep all 64 {op,ra} combinations with in_valid=1 -> registered outputs match the decode table one cycle later, e.g. op=0111/ra=01 -> ctl=0010, SE2=1, SE3=00; op=1000/ra=11 -> ctl=1101; op=1111 -> illegal=1.
- int_req pulse with INT_CYCLES=2 while op=0011 is presented:
  - -> 2 clocks of ex_valid=1, ctl=0000, SE3=01, int_step=0 then 1;
  - -> 1 bubble clock (DRAIN);
  - -> int_busy high for 3 clocks;
  - -> op=0011 issues after int_busy falls.
- stall=1 for 3 clocks during INT slot 0 -> outputs and int_step frozen at 0; the sequence resumes and still completes exactly 2 slots.
- flush=1 with op=0001 in IDLE -> ex_valid=0, SE3=00. flush=1 during INT -> slot still issued with ex_valid=1, SE3=01.
- flush and int_req together in IDLE -> bubble loaded, FSM stays IDLE. int_req held into the next clock -> entry begins.
